// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared mode type and width helper
// for the registered N-channel stream mux.
package stream_mux_pkg;

    typedef enum logic {
        SEL_EXPLICIT,
        SEL_RR
    } mode_e;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: producer-side and consumer-side
// handshake bundle of the stream mux.
interface stream_mux_rr_if
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3
);
    localparam int CW = clog2_min1(CHANNELS);

    logic                cs;
    logic [CW-1:0]       sel;
    logic [CHANNELS-1:0] in_valid;
    logic [WIDTH-1:0]    in_data [CHANNELS];
    logic [CHANNELS-1:0] in_ready;
    logic                out_valid;
    logic [WIDTH-1:0]    out_data;
    logic [CW-1:0]       out_chan;
    logic                out_ready;

    modport master (
        output cs, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  cs, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: round-robin grant over N requests; the
// pointer remembers the last served channel.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N = 3,
    parameter int W = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_vld
);
    logic [W-1:0] ptr;
    logic [W-1:0] idx;

    // scan backwards so the nearest request after ptr wins
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int k = N; k >= 1; k--) begin
            idx = W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= W'(N - 1);
        end else if (advance && gnt_vld) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready mux with chip select
// and one output register; explicit-select or round-robin.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int    WIDTH    = 8,
    parameter int    CHANNELS = 3,
    parameter mode_e MODE     = SEL_EXPLICIT
) (
    input  logic          clk,
    input  logic          rst_n,
    stream_mux_rr_if.slave bus
);
    localparam int CW = clog2_min1(CHANNELS);

    logic [CW-1:0]       g;
    logic                gnt_vld;
    logic                space;
    logic                xfer;
    logic [CHANNELS-1:0] ready;
    logic [WIDTH-1:0]    word;

    logic                valid_q;
    logic [WIDTH-1:0]    data_q;
    logic [CW-1:0]       chan_q;

    generate
        if (MODE == SEL_RR) begin : g_rr
            rr_arbiter #(
                .N (CHANNELS),
                .W (CW)
            ) u_arb (
                .clk     (clk),
                .rst_n   (rst_n),
                .req     (bus.in_valid),
                .advance (xfer),
                .gnt_idx (g),
                .gnt_vld (gnt_vld)
            );
        end else begin : g_sel
            assign g       = bus.sel;
            assign gnt_vld = int'(bus.sel) < CHANNELS;
        end
    endgenerate

    assign space = !valid_q || bus.out_ready;

    // one-hot decode keeps out-of-range codes from indexing
    always_comb begin
        ready = '0;
        word  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt_vld && g == CW'(i)) begin
                ready[i] = bus.cs && space;
                word     = bus.in_data[i];
            end
        end
    end

    assign xfer = |(ready & bus.in_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
        end else if (xfer) begin
            valid_q <= 1'b1;
            data_q  <= word;
            chan_q  <= g;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;

endmodule
